// File: rtl/delayprog_multich.sv
// Multi-channel programmable edge delay with glitch rejection.
// Each channel: input synchroniser feeding an IDLE/COUNT timing FSM.
module delayprog_multich #(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int SYNC = 2
) (
    input  logic              CELCLK,
    input  logic              CELRSTN,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              CELSUB,
    input  logic [NCH-1:0]    i,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] dly,
    input  logic [NCH*2-1:0]  mode,
    output logic [NCH-1:0]    o,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);
    typedef enum logic {IDLE, COUNT} state_t;

    state_t [NCH-1:0]         st;
    logic [NCH-1:0][SYNC-1:0] sync_q;
    logic [NCH-1:0][CW-1:0]   cnt;
    logic [NCH-1:0][CW-1:0]   dly_l;
    logic [NCH-1:0][1:0]      mode_l;
    logic [NCH-1:0]           isync;
    logic [NCH-1:0]           qual;
    logic                     unused_ok;

    // Supply pins and the latched mode carry no function in RTL.
    assign unused_ok = ^{CELV, CELG, CELSUB, mode_l};

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            sync_q <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                sync_q[n] <= {sync_q[n][SYNC-2:0], i[n]};
            end
        end
    end

    // Edge direction selected by mode; meaningful only when isync differs from o.
    always_comb begin
        isync = '0;
        qual  = '0;
        for (int n = 0; n < NCH; n++) begin
            isync[n] = sync_q[n][SYNC-1];
            unique case (mode[2*n +: 2])
                2'b00:   qual[n] = isync[n];
                2'b01:   qual[n] = ~isync[n];
                2'b10:   qual[n] = 1'b1;
                default: qual[n] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            for (int n = 0; n < NCH; n++) begin
                st[n]     <= IDLE;
                cnt[n]    <= '0;
                dly_l[n]  <= '0;
                mode_l[n] <= '0;
                o[n]      <= 1'b0;
                busy[n]   <= 1'b0;
                done[n]   <= 1'b0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                done[n] <= 1'b0;
                if (!en[n]) begin
                    st[n]   <= IDLE;
                    cnt[n]  <= '0;
                    o[n]    <= 1'b0;
                    busy[n] <= 1'b0;
                end else begin
                    unique case (st[n])
                        IDLE: begin
                            if (isync[n] != o[n]) begin
                                if (!qual[n] || dly[n*CW +: CW] == '0) begin
                                    o[n]    <= isync[n];
                                    done[n] <= qual[n];
                                end else begin
                                    st[n]     <= COUNT;
                                    cnt[n]    <= CW'(1);
                                    dly_l[n]  <= dly[n*CW +: CW];
                                    mode_l[n] <= mode[2*n +: 2];
                                    busy[n]   <= 1'b1;
                                end
                            end
                        end
                        COUNT: begin
                            // A return of the input beats a terminal count.
                            if (isync[n] == o[n]) begin
                                st[n]   <= IDLE;
                                cnt[n]  <= '0;
                                busy[n] <= 1'b0;
                            end else if (cnt[n] == dly_l[n]) begin
                                st[n]   <= IDLE;
                                cnt[n]  <= '0;
                                busy[n] <= 1'b0;
                                o[n]    <= isync[n];
                                done[n] <= 1'b1;
                            end else begin
                                cnt[n] <= cnt[n] + CW'(1);
                            end
                        end
                        default: st[n] <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_delayprog_multich.sv
// Directed bench for delayprog_multich (NCH=4, CW=8, SYNC=2).
module tb_delayprog_multich;
    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int MAXC = 400;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            celv = 1'b1;
    logic            celg = 1'b0;
    logic            celsub = 1'b0;
    logic [NCH-1:0]  i;
    logic [NCH-1:0]  en;
    logic [NCH*CW-1:0] dly;
    logic [NCH*2-1:0]  mode;
    logic [NCH-1:0]  o;
    logic [NCH-1:0]  busy;
    logic [NCH-1:0]  done;

    int checks = 0;
    int errors = 0;

    logic [1:0] md [NCH];
    int dl [NCH];
    int wid [NCH];
    int st_e [NCH];
    int chg_e;
    logic [CW-1:0] chg_v;
    logic [NCH-1:0] ob_o [MAXC];
    logic [NCH-1:0] ob_b [MAXC];
    logic [NCH-1:0] ob_d [MAXC];

    delayprog_multich #(.NCH(NCH), .CW(CW), .SYNC(2)) dut (
        .CELCLK(clk), .CELRSTN(rst_n),
        .CELV(celv), .CELG(celg), .CELSUB(celsub),
        .i(i), .en(en), .dly(dly), .mode(mode),
        .o(o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected {o,busy,done} k edges after the rise capture of a w-cycle pulse.
    function automatic logic [2:0] ref_at(input logic [1:0] m, input int d,
                                          input int w, input int k);
        bit rd, fd;
        int r, f;
        logic ov, bv, dv;
        rd = (m == 2'b00) || (m == 2'b10);
        fd = (m == 2'b01) || (m == 2'b10);
        if (w == 0 || k < 2) return 3'b000;
        if (rd && d > 0 && w < d + 1) begin
            bv = (k <= w + 1);
            return {1'b0, bv, 1'b0};
        end
        r  = rd ? 2 + d : 2;
        f  = fd ? w + 2 + d : w + 2;
        ov = (k >= r) && (k < f);
        bv = (rd && k < r) || (fd && k >= w + 2 && k < f);
        dv = (rd && k == r) || (fd && k == f);
        return {ov, bv, dv};
    endfunction

    task automatic clear_cfg();
        for (int n = 0; n < NCH; n++) begin
            md[n] = 2'b00; dl[n] = 1; wid[n] = 0; st_e[n] = 0;
        end
        chg_e = -1;
        chg_v = '0;
    endtask

    task automatic apply_cfg();
        for (int n = 0; n < NCH; n++) begin
            dly[n*CW +: CW] = CW'(dl[n]);
            mode[n*2 +: 2]  = md[n];
        end
    endtask

    // Called just after a clock edge; loop index e is the capture edge number.
    task automatic run_pulses(input int ncyc);
        for (int e = 0; e < ncyc; e++) begin
            for (int n = 0; n < NCH; n++)
                i[n] = (wid[n] > 0) && (e >= st_e[n]) && (e < st_e[n] + wid[n]);
            if (e == chg_e) dly[CW-1:0] = chg_v;
            @(posedge clk); #1;
            ob_o[e] = o; ob_b[e] = busy; ob_d[e] = done;
        end
        i = '0;
        apply_cfg();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '1; mode = '0; dly = '0;
        for (int c = 0; c < 4; c++) begin
            i = NCH'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({o, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset c%0d: got %b exp 0", c, {o, busy, done});
            end
        end
        i = '0;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_first_pulse();
        clear_cfg(); md[0] = 2'b00; dl[0] = 5; wid[0] = 20; apply_cfg();
        run_pulses(26);
        for (int e = 0; e < 26; e++) for (int n = 0; n < NCH; n++) begin
            logic [2:0] ex = ref_at(md[n], dl[n], wid[n], e - st_e[n]);
            checks++;
            if ({ob_o[e][n], ob_b[e][n], ob_d[e][n]} !== ex) begin
                errors++;
                $display("FAIL first ch%0d e%0d: got %b exp %b", n, e,
                         {ob_o[e][n], ob_b[e][n], ob_d[e][n]}, ex);
            end
        end
    endtask

    task automatic test_glitch();
        int ws [3] = '{4, 5, 6};
        for (int t = 0; t < 3; t++) begin
            clear_cfg(); md[0] = 2'b00; dl[0] = 5; wid[0] = ws[t]; apply_cfg();
            run_pulses(14);
            for (int e = 0; e < 14; e++) begin
                logic [2:0] ex = ref_at(md[0], dl[0], wid[0], e);
                checks++;
                if ({ob_o[e][0], ob_b[e][0], ob_d[e][0]} !== ex) begin
                    errors++;
                    $display("FAIL glitch w%0d e%0d: got %b exp %b", ws[t], e,
                             {ob_o[e][0], ob_b[e][0], ob_d[e][0]}, ex);
                end
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0] ms [3] = '{2'b01, 2'b10, 2'b11};
        for (int t = 0; t < 3; t++) begin
            clear_cfg(); md[0] = ms[t]; dl[0] = 3; wid[0] = 10; apply_cfg();
            run_pulses(20);
            for (int e = 0; e < 20; e++) begin
                logic [2:0] ex = ref_at(md[0], dl[0], wid[0], e);
                checks++;
                if ({ob_o[e][0], ob_b[e][0], ob_d[e][0]} !== ex) begin
                    errors++;
                    $display("FAIL mode%b e%0d: got %b exp %b", ms[t], e,
                             {ob_o[e][0], ob_b[e][0], ob_d[e][0]}, ex);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [1:0] ms [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        int ds [6] = '{0, 0, 255, 5, 5, 5};
        int ws [6] = '{5, 5, 300, 20, 20, 5};
        int ce [6] = '{-1, -1, -1, 4, 4, -1};
        logic [7:0] cv [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd200, 8'd0};
        int nc [6] = '{12, 12, 306, 26, 26, 12};
        for (int t = 0; t < 6; t++) begin
            clear_cfg(); md[0] = ms[t]; dl[0] = ds[t]; wid[0] = ws[t];
            chg_e = ce[t]; chg_v = cv[t]; apply_cfg();
            run_pulses(nc[t]);
            for (int e = 0; e < nc[t]; e++) begin
                logic [2:0] ex = ref_at(md[0], dl[0], wid[0], e);
                checks++;
                if ({ob_o[e][0], ob_b[e][0], ob_d[e][0]} !== ex) begin
                    errors++;
                    $display("FAIL bound t%0d e%0d: got %b exp %b", t, e,
                             {ob_o[e][0], ob_b[e][0], ob_d[e][0]}, ex);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ds [2] = '{3, 2};
        int ws [2] = '{4, 3};
        for (int t = 0; t < 2; t++) begin
            clear_cfg(); md[0] = 2'b10; dl[0] = ds[t]; wid[0] = ws[t]; apply_cfg();
            run_pulses(14);
            for (int e = 0; e < 14; e++) begin
                logic [2:0] ex = ref_at(md[0], dl[0], wid[0], e);
                checks++;
                if ({ob_o[e][0], ob_b[e][0], ob_d[e][0]} !== ex) begin
                    errors++;
                    $display("FAIL b2b t%0d e%0d: got %b exp %b", t, e,
                             {ob_o[e][0], ob_b[e][0], ob_d[e][0]}, ex);
                end
            end
        end
    endtask

    task automatic test_async_abort();
        clear_cfg(); md[0] = 2'b00; dl[0] = 5; apply_cfg();
        i[0] = 1'b1;
        for (int e = 0; e <= 4; e++) begin @(posedge clk); #1; end
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL abort_busy: got %b exp 1", busy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o, busy, done} !== '0) begin
            errors++; $display("FAIL abort_async: got %b exp 0", {o, busy, done});
        end
        i = '0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if ({o, busy, done} !== '0) begin
                errors++; $display("FAIL abort_hold: got %b exp 0", {o, busy, done});
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({o[0], busy[0], done[0]} !== 3'b000) begin
                errors++;
                $display("FAIL abort_after c%0d: got %b exp 000", c, {o[0], busy[0], done[0]});
            end
        end
        wid[0] = 20;
        run_pulses(26);
        for (int e = 0; e < 26; e++) begin
            logic [2:0] ex = ref_at(md[0], dl[0], wid[0], e);
            checks++;
            if ({ob_o[e][0], ob_b[e][0], ob_d[e][0]} !== ex) begin
                errors++;
                $display("FAIL abort_recover e%0d: got %b exp %b", e,
                         {ob_o[e][0], ob_b[e][0], ob_d[e][0]}, ex);
            end
        end
    endtask

    task automatic test_enable();
        clear_cfg(); md[0] = 2'b00; dl[0] = 5; apply_cfg();
        i[0] = 1'b1;
        for (int e = 0; e <= 4; e++) begin @(posedge clk); #1; end
        en[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({o[0], busy[0], done[0]} !== 3'b000) begin
                errors++;
                $display("FAIL en_off c%0d: got %b exp 000", c, {o[0], busy[0], done[0]});
            end
        end
        dly[CW-1:0] = 8'd3;
        en[0] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            logic [2:0] ex;
            @(posedge clk); #1;
            ex = {j >= 4, j >= 1 && j < 4, j == 4};
            checks++;
            if ({o[0], busy[0], done[0]} !== ex) begin
                errors++;
                $display("FAIL en_rearm j%0d: got %b exp %b", j, {o[0], busy[0], done[0]}, ex);
            end
        end
        i[0] = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            logic [2:0] ex;
            @(posedge clk); #1;
            ex = {j < 3, 1'b0, 1'b0};
            checks++;
            if ({o[0], busy[0], done[0]} !== ex) begin
                errors++;
                $display("FAIL en_fall j%0d: got %b exp %b", j, {o[0], busy[0], done[0]}, ex);
            end
        end
        apply_cfg();
    endtask

    task automatic test_channels();
        for (int t = 0; t < 2; t++) begin
            clear_cfg();
            if (t == 0) begin
                md = '{2'b00, 2'b01, 2'b10, 2'b11};
                dl = '{5, 2, 4, 7}; wid = '{8, 6, 12, 5}; st_e = '{0, 3, 1, 5};
            end else begin
                md = '{2'b00, 2'b10, 2'b01, 2'b00};
                dl = '{9, 1, 6, 0}; wid = '{4, 3, 2, 7}; st_e = '{0, 0, 0, 0};
            end
            apply_cfg();
            run_pulses(26);
            for (int e = 0; e < 26; e++) for (int n = 0; n < NCH; n++) begin
                logic [2:0] ex = ref_at(md[n], dl[n], wid[n], e - st_e[n]);
                checks++;
                if ({ob_o[e][n], ob_b[e][n], ob_d[e][n]} !== ex) begin
                    errors++;
                    $display("FAIL chan t%0d ch%0d e%0d: got %b exp %b", t, n, e,
                             {ob_o[e][n], ob_b[e][n], ob_d[e][n]}, ex);
                end
            end
        end
    endtask

    initial begin
        i = '0;
        clear_cfg();
        test_reset();
        test_first_pulse();
        test_glitch();
        test_modes();
        test_boundaries();
        test_back_to_back();
        test_async_abort();
        test_enable();
        test_channels();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/delayprog_multich.md
# delayprog_multich

Parametrised, clocked multi-channel edge-delay block, successor to the fixed 10ns single-edge delay cells. Each channel delays its selected edge(s) by a programmable number of clock cycles and rejects pulses shorter than that delay. The other edge passes with synchroniser latency only. It sits in CONTROL-loop and STEPDOWN blanking/deglitch paths wherever a fixed analog delay cell is too inflexible.

## Interface

**Parameters**
- NCH, 4: number of independent channels.
- CW, 8: delay counter width. Maximum delay is 2^CW−1 cycles.
- SYNC, 2: input synchroniser depth (≥2).

**Ports**
- CELCLK  input  1  block clock; all flops on rising edge.
- CELRSTN  input  1  asynchronous, active-low reset.
- CELV, CELG, CELSUB  input  1 each  supply/ground/substrate; no functional effect in RTL.
- i  input  NCH  asynchronous channel inputs.
- en  input  NCH  per-channel enable.
- dly  input  NCH*CW  per-channel delay in cycles; channel n uses bits [n*CW +: CW].
- mode  input  NCH*2  per-channel edge select; 00 = rise delayed, 01 = fall delayed, 10 = both delayed, 11 = none delayed.
- o  output  NCH  delayed outputs, registered.
- busy  output  NCH  channel is timing a qualifying edge.
- done  output  NCH  one-cycle pulse when a delayed edge propagates to o.

## Operation

- **Synchroniser.** Each i[n] passes through SYNC flops, reset to 0. The last stage is is[n].
- **Per-channel FSM**, with states IDLE and COUNT, a counter cnt[CW], and latched copies dly_l and mode_l.
- **Qualifying edge.** is≠o and the edge direction (is=1 means rise, is=0 means fall) is selected by mode. mode 11 never qualifies.
- **IDLE** (in every case below, busy=0 unless stated):
  - is==o: hold.
  - is≠o and not qualifying: o<=is at that edge. done stays 0.
  - is≠o, qualifying, dly==0: o<=is and done=1 at that edge.
  - is≠o, qualifying, dly>0: go to COUNT with cnt<=1, latch dly_l<=dly and mode_l<=mode, busy<=1.
- **COUNT** (dly_l and mode_l are used; live dly/mode changes are ignored until the next entry):
  - is==o, meaning the input returned: go to IDLE, cnt<=0, busy<=0, o unchanged, no done. The glitch is rejected.
  - is≠o and cnt==dly_l: o<=is, done<=1, cnt<=0, busy<=0, go to IDLE.
  - Otherwise cnt<=cnt+1.
- **Enable.** en[n]=0 forces IDLE, cnt=0, o=0, busy=0, done=0 on the next edge. The synchroniser keeps running.
- **Re-enable.** When en returns to 1, the FSM starts from o=0. If is=1, that is a rising edge and is treated per mode.
- **Arithmetic.** cnt never wraps, because the compare against dly_l ends COUNT first.
- **Channel independence.** Channels share no state.

## Timing

- **Reset.** While CELRSTN=0: all sync flops, o, busy, done, cnt and dly_l read 0, and the FSM is IDLE. Reset applied mid-COUNT aborts the count with no done. On release, operation resumes at the first CELCLK edge.
- **Edge numbering.** Edge 0 is the CELCLK edge at which the first sync flop captures an i transition. is changes at edge SYNC−1.
- **Latency, non-delayed edge:** o changes at edge SYNC.
- **Latency, delayed edge:** the FSM enters COUNT at edge SYNC and o changes at edge SYNC+dly. done is high for the one cycle following that edge. For dly==0, o and done change at edge SYNC.
- **Minimum pulse passed.** A delayed-edge input pulse must stay at its new level through edge SYNC+dly to propagate. If is returns at or before that edge, the pulse is rejected.
- **Simultaneous events.** If is returns to o at the same edge where cnt==dly_l, the return wins: abort, no done.
- **Back-to-back.** After done, a new qualifying edge can enter COUNT on the very next edge.
- **Enable timing.** en falling mid-COUNT aborts with no done. en takes effect at the next edge with one cycle of latency.

## Test plan

- **Reset values.** Hold CELRSTN=0 with random i → o, busy and done all 0. Release, set en=1, mode=00, dly=5, and raise i at edge 0 → o rises at edge 7 (SYNC=2). busy is high for edges 2–6 inclusive. done pulses once after edge 7.
- **Glitch rejection.** mode=00, dly=5, i high for 4 cycles → o stays 0, busy drops on return, no done. Repeat with a 6-cycle pulse → o rises at edge 7, then falls at edge 2 after the i fall (immediate edge).
- **Mode sweep.** Run modes 01, 10 and 11 with dly=3 against a 10-cycle pulse.
  - 01: rise at edge 2, fall delayed +3.
  - 10: both edges delayed +3.
  - 11: both at edge 2, never busy or done.
- **Boundaries.**
  - dly=0: qualifying edge at edge 2 with done.
  - dly=255: o changes at edge 257.
  - Change dly mid-COUNT → the latched value is used.
  - Return i on exactly the terminal edge → abort.
- **Async abort.** Pulse CELRSTN low mid-COUNT and separately drop en mid-COUNT → o=0, busy=0, no done. Recovery behaves as in the first scenario.
- **Channel independence.** Drive all NCH channels with distinct dly and mode concurrently and staggered → each matches its own single-channel reference, with no cross-talk.
